rfphoenix_insn_fifo_drain: RTL
==============================

// Module: rfPhoenix_insn_fifo_drain
// PURPOSE
//  Read-side controller for the instruction FIFO (xpm std mode, read latency 1, data_valid).
//  Issues rd_en, captures {decode_bus_t,instruction_fetchbuf_t} words into a 2-entry skid
//  buffer and presents them to the issue stage as a valid/ready stream at full throughput.
//  Handles pipeline flush, counts consumer stalls and flags protocol errors from the FIFO.
// PARAMETERS
//  W       $bits(decode_bus_t)+$bits(instruction_fetchbuf_t)  word width, matches FIFO dout
//  SCNT_W  16   width of saturating stall counter
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-low
//  fifo_empty in   1       FIFO empty flag
//  fifo_v     in   1       FIFO data_valid; fifo_dat meaningful this cycle
//  fifo_dat   in   W       FIFO dout {decout,ifbout}
//  fifo_rd    out  1       FIFO rd_en (combinational)
//  flush      in   1       discard all buffered and in-flight words this cycle
//  out_valid  out  1       out_data holds a valid word
//  out_data   out  W       head word of skid buffer (registered)
//  out_ready  in   1       consumer accepts head when out_valid&out_ready
//  occ        out  2       skid occupancy 0..2
//  stall_cnt  out  SCNT_W  cycles with out_valid&!out_ready, saturating
//  proto_err  out  1       sticky: fifo_v seen with no read in flight
// BEHAVIOUR
//  Reset (rst=0, async): occ=0, inflight=0, out_valid=0, out_data=0, stall_cnt=0, proto_err=0;
//   fifo_rd=0 while rst=0.
//  State: skid occupancy EMPTY(0)/ONE(1)/TWO(2); inflight flag = fifo_rd registered.
//  pop = out_valid & out_ready; out_valid = (occ!=0); out_data = entry[head].
//  fifo_rd = !fifo_empty & !flush & (occ + inflight - pop < 2); never exceeds capacity.
//  Capture: fifo_v=1 & !flush -> write fifo_dat at tail; same-cycle pop and capture allowed
//   (occ unchanged, head advances). Entries kept in FIFO order; head/tail 1-bit, wrap at 2.
//  Latency: FIFO non-empty, occ=0, no flush: fifo_rd at t, fifo_v at t+1, out_valid at t+2.
//  Throughput: steady stream with out_ready=1 gives one word per cycle (occ=1,inflight=1).
//  Backpressure: out_ready=0 -> reads stop once occ+inflight=2; no word lost or duplicated.
//  fifo_empty=1 -> fifo_rd=0; out_valid stays high while occ>0.
//  Flush (sync): next occ=0, out_valid=0, inflight=0; fifo_v/fifo_dat in flush cycle dropped;
//   fifo_rd=0 in flush cycle; pop in flush cycle ignored for ordering (word is discarded).
//   Caller resets/flushes the FIFO itself; first post-flush read earliest at t+1.
//  stall_cnt += 1 each cycle out_valid&!out_ready, holds at all-ones; cleared only by reset.
//  proto_err set when fifo_v=1 & inflight=0 (outside flush cycle); sticky until reset.
//  fifo_v=1 arriving with occ=2 and no pop is impossible by credit rule; if seen, word
//   dropped and proto_err set.
//  Reset mid-transfer: all state cleared immediately; in-flight word not captured.
// TESTING
//  T1 reset: rst=0 with fifo_empty=0 -> fifo_rd=0,out_valid=0,occ=0,stall_cnt=0,proto_err=0.
//  T2 latency: push 1 word 0x5A.., out_ready=1 -> fifo_rd at t, out_valid at t+2 data 0x5A..
//  T3 streaming: 16 words 0..15, out_ready=1 -> 16 consecutive out_valid cycles, data 0..15.
//  T4 backpressure: 8 words, out_ready=0 10 cycles -> occ=2, exactly 2 reads, stall_cnt=8;
//     then out_ready=1 -> words 0..7 in order, no gaps after first.
//  T5 flush: stream 8 words, flush at cycle 5 with read in flight -> occ=0 next cycle,
//     dropped word never appears, proto_err=0, remaining words resume in order.
//  T6 error: fifo_v=1 with no prior fifo_rd -> proto_err=1, held until rst=0.

Source files
------------

// File: rtl/rfphoenix_insn_fifo_drain.sv
// Read-side drain for the instruction FIFO: credit-based rd_en issue, 2-entry skid
// buffer feeding the issue stage as a valid/ready stream, flush, stall count and error flag.
module rfphoenix_insn_fifo_drain #(
  parameter int W      = 64,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_v,
  input  logic [W-1:0]      fifo_dat,
  output logic              fifo_rd,
  input  logic              flush,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  input  logic              out_ready,
  output logic [1:0]        occ,
  output logic [SCNT_W-1:0] stall_cnt,
  output logic              proto_err
);

  logic [1:0][W-1:0] entry;
  logic              head, tail, inflight;
  logic              pop, full, wr;
  logic [2:0]        credit;

  assign out_valid = (occ != 2'd0);
  assign out_data  = entry[head];
  assign pop       = out_valid & out_ready;
  assign full      = (occ == 2'd2);

  // Words already committed (buffered + in flight) after this cycle's pop must leave
  // room for the word this read will return.
  assign credit  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd = rst & ~fifo_empty & ~flush & (credit < 3'd2);

  // A full buffer with no pop cannot take a word; it is dropped and flagged.
  assign wr = fifo_v & ~flush & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry     <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      stall_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (out_valid & ~out_ready & ~(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (fifo_v & ~flush & (~inflight | (full & ~pop)))
        proto_err <= 1'b1;
      if (flush) begin
        occ  <= 2'd0;
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (wr) begin
          entry[tail] <= fifo_dat;
          tail        <= ~tail;
        end
        if (pop)
          head <= ~head;
        occ <= occ + {1'b0, wr} - {1'b0, pop};
      end
    end
  end

endmodule
